stall_fifo: RTL and testbench

//  Parametrised successor to the ID-stage stall queue: circular-buffer FIFO holding

---
 rtl/stall_fifo.sv | 91 +++++++++
 tb/tb_stall_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stall_fifo.sv
// Circular-buffer stall queue between ID and EX: holds decode bundles until operands are ready.
// Optional zero-cycle fall-through when empty is enabled by defining STALL_FIFO_BYPASS_EN.
module stall_fifo #(
  parameter int WIDTH  = 121,
  parameter int DEPTH  = 4,
  parameter int AF_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           rear,
  input  logic                       pop,
  output logic [WIDTH-1:0]           front,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf_q, udf_q;

  logic stored_empty, stored_full;
  logic push_acc, pop_acc, ovf_set, udf_set;

  assign stored_empty = (cnt == '0);
  assign stored_full  = (cnt == FULL_CNT);

`ifdef STALL_FIFO_BYPASS_EN
  // push+pop on an empty queue forwards rear straight through and stores nothing
  logic fall_through;
  assign fall_through = stored_empty & push & pop;
  assign pop_acc      = pop & ~stored_empty;
  assign push_acc     = push & ~fall_through & (~stored_full | pop);
  assign udf_set      = pop & stored_empty & ~push;
  assign empty        = stored_empty & ~push;
  assign front        = stored_empty ? (push ? rear : '0) : mem[rd_ptr];
`else
  assign pop_acc      = pop & ~stored_empty;
  assign push_acc     = push & (~stored_full | pop);
  assign udf_set      = pop & stored_empty;
  assign empty        = stored_empty;
  assign front        = stored_empty ? '0 : mem[rd_ptr];
`endif

  assign ovf_set     = push & stored_full & ~pop;
  assign full        = stored_full;
  assign almost_full = (cnt >= AF_CNT);
  assign count       = cnt;
  assign ovf         = ovf_q;
  assign udf         = udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (push_acc && !pop_acc)      cnt <= cnt + 1'b1;
      else if (pop_acc && !push_acc) cnt <= cnt - 1'b1;
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  // NOTE: storage has no reset; count gates front to 0 so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push_acc && !flush) mem[wr_ptr] <= rear;
  end

endmodule

// File: tb/tb_stall_fifo.sv
// Scoreboard bench for stall_fifo (DEPTH=4, AF_LVL=3); honours STALL_FIFO_BYPASS_EN if defined.
module tb_stall_fifo;

  localparam int WIDTH  = 121;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;

  logic             clk = 1'b0;
  logic             rst_n, flush, push, pop;
  logic [WIDTH-1:0] rear, front;
  logic             empty, full, almost_full, ovf, udf;
  logic [2:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic             m_ovf, m_udf;

  stall_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .rear(rear), .pop(pop),
    .front(front), .empty(empty), .full(full), .almost_full(almost_full),
    .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input logic [15:0] t);
    logic [WIDTH-1:0] v;
    v = {t, 105'd0} | WIDTH'(t);
    return v;
  endfunction

  task automatic check_state(input string tag);
    int n;
    n = sb_q.size();
    check({tag, ".count"}, 128'(count), 128'(n));
    check({tag, ".empty"}, 128'(empty), 128'(n == 0));
    check({tag, ".full"},  128'(full),  128'(n == DEPTH));
    check({tag, ".af"},    128'(almost_full), 128'(n >= AF_LVL));
    check({tag, ".ovf"},   128'(ovf), 128'(m_ovf));
    check({tag, ".udf"},   128'(udf), 128'(m_udf));
    check({tag, ".front"}, 128'(front), (n == 0) ? 128'(0) : 128'(sb_q[0]));
  endtask

  // Drive one cycle; compare popped data against the scoreboard, then check registered state.
  task automatic step(input string tag, input logic f, input logic p,
                      input logic [WIDTH-1:0] d, input logic po);
    logic was_empty, was_full;
    flush = f; push = p; rear = d; pop = po;
    #1;
    was_empty = (sb_q.size() == 0);
    was_full  = (sb_q.size() == DEPTH);
    if (f) begin
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
`ifdef STALL_FIFO_BYPASS_EN
      if (was_empty && p) begin
        check({tag, ".byp_front"}, 128'(front), 128'(d));
        check({tag, ".byp_empty"}, 128'(empty), 128'(0));
      end
      if (was_empty && p && po) begin
        // forwarded only: nothing stored, no underflow
      end else begin
`else
      begin
`endif
        if (po) begin
          if (was_empty) m_udf = 1'b1;
          else check({tag, ".pop"}, 128'(front), 128'(sb_q.pop_front()));
        end
        if (p) begin
          if (!was_full || po) sb_q.push_back(d);
          else m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0; rear = '0;
    #1;
    check_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; rear = '0;
    m_ovf = 1'b0; m_udf = 1'b0;
    #12;
    check_state("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // fill: almost_full at 3, full at 4, 5th push dropped with ovf
    for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b1, mk(16'hA0 + 16'(i)), 1'b0);
    step("ovf_push", 1'b0, 1'b1, mk(16'h0BAD), 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, '0, 1'b0 | 1'b1);

    // wrap: hold count at 2 while streaming
    step("clr", 1'b1, 1'b0, '0, 1'b0);
    step("w0", 1'b0, 1'b1, mk(16'h0D00), 1'b0);
    step("w1", 1'b0, 1'b1, mk(16'h0D01), 1'b0);
    for (int i = 2; i < 12; i++) step("wrap", 1'b0, 1'b1, mk(16'h0D00 + 16'(i)), 1'b1);

    // full push+pop: head consumed, B5 joins tail, no ovf
    step("clr2", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 4; i++) step("fill2", 1'b0, 1'b1, mk(16'hA0 + 16'(i)), 1'b0);
    step("full_pp", 1'b0, 1'b1, mk(16'h00B5), 1'b1);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 1'b0, '0, 1'b1);

    // flush beats a simultaneous push
    for (int i = 1; i <= 3; i++) step("fill3", 1'b0, 1'b1, mk(16'hF0 + 16'(i)), 1'b0);
    step("flush", 1'b1, 1'b1, mk(16'h0F1F), 1'b0);

    // pop on empty alone, then push+pop on empty
    step("udf_only", 1'b0, 1'b0, '0, 1'b1);
    step("clr3", 1'b1, 1'b0, '0, 1'b0);
    step("c7", 1'b0, 1'b1, mk(16'h00C7), 1'b1);
    step("c7_out", 1'b0, 1'b0, '0, 1'b1);

    // random mix
    for (int i = 0; i < 60; i++)
      step("rnd", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           mk(16'($urandom)), 1'($urandom_range(0, 1)));

    // async reset with 3 entries held
    step("clr4", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 3; i++) step("fill4", 1'b0, 1'b1, mk(16'hE0 + 16'(i)), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b1, mk(16'h0123), 1'b0);
    step("post_rst_pop", 1'b0, 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
